ifetch_unit: RTL and testbench

- Instruction fetch stage sitting directly upstream of the decode/control stage.
- Owns the architectural PC and issues word fetches to instruction memory over a req/ack handshake, which may have variable latency.
- Buffers fetched words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from downstream, flushes stale work, and restarts fetch at the target.

---
 rtl/ifetch_unit.sv | 118 +++++++++++
 tb/tb_ifetch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack port,
// queues {pc, instr} pairs for decode and handles redirect flushes.
//
// state   | meaning
// S_FETCH | issue fetches at fetch_pc while the queue has room
// S_DROP  | drain the one request abandoned by a redirect, discard its data
module ifetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  output logic                       dec_valid,
  output logic [31:0]                dec_instr,
  output logic [31:0]                dec_pc,
  input  logic                       dec_ready,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] fq_count
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam int            PW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {S_FETCH = 1'b0, S_DROP = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   drop_addr_q, drop_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   fq_instr_q [DEPTH];
  logic [31:0]   fq_instr_d [DEPTH];
  logic [31:0]   fq_pc_q    [DEPTH];
  logic [31:0]   fq_pc_d    [DEPTH];
  logic          push, pop;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
    fq_instr_q <= fq_instr_d;
    fq_pc_q    <= fq_pc_d;
  end

  // A redirect with a request in flight must still wait out that ack.
  always_comb begin
    state_d     = state_q;
    drop_addr_d = drop_addr_q;
    unique case (state_q)
      S_FETCH: if (redirect && imem_req && !imem_ack) begin
        state_d     = S_DROP;
        drop_addr_d = fetch_pc_q;
      end
      S_DROP:  if (imem_ack) state_d = S_FETCH;
    endcase
  end

  // Request is gated by reset so a withdrawn fetch is visible immediately.
  always_comb begin
    imem_req  = reset && ((state_q == S_DROP) || (count_q < FULL));
    imem_addr = (state_q == S_DROP) ? drop_addr_q : fetch_pc_q;
    dec_valid = (count_q != '0) && !redirect;
    dec_instr = (count_q != '0) ? fq_instr_q[rd_ptr_q] : '0;
    dec_pc    = (count_q != '0) ? fq_pc_q[rd_ptr_q]    : '0;
    fq_count  = count_q;
  end

  assign push = (state_q == S_FETCH) && imem_req && imem_ack && !redirect;
  assign pop  = dec_valid && dec_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    fq_instr_d = fq_instr_q;
    fq_pc_d    = fq_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fq_instr_d[wr_ptr_q] = imem_rdata;
        fq_pc_d[wr_ptr_q]    = fetch_pc_q;
        wr_ptr_d             = wr_ptr_q + PW'(1);
        fetch_pc_d           = fetch_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: inputs driven and outputs checked half a
// cycle away from the rising edge; instruction data is addr ^ 32'hA5A5_0000.
module tb_ifetch_unit;

  logic        clock       = 1'b0;
  logic        reset       = 1'b0;
  logic        imem_ack    = 1'b0;
  logic        dec_ready   = 1'b0;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic        dec_valid;
  logic [31:0] imem_addr;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [1:0]  fq_count;
  wire  [31:0] imem_rdata;

  int nvec        = 0;
  int miscompares = 0;

  localparam logic [31:0] XM = 32'hA5A5_0000;

  assign imem_rdata = imem_addr ^ XM;

  ifetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dec_valid  (dec_valid),
    .dec_instr  (dec_instr),
    .dec_pc     (dec_pc),
    .dec_ready  (dec_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .fq_count   (fq_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req"},   32'(imem_req),  32'd0);
    check({tag, ".addr"},  imem_addr,      32'h0);
    check({tag, ".dv"},    32'(dec_valid), 32'd0);
    check({tag, ".instr"}, dec_instr,      32'h0);
    check({tag, ".pc"},    dec_pc,         32'h0);
    check({tag, ".cnt"},   32'(fq_count),  32'd0);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, ".dv"},    32'(dec_valid), 32'd1);
    check({tag, ".pc"},    dec_pc,         pc);
    check({tag, ".instr"}, dec_instr,      pc ^ XM);
  endtask

  initial begin
    // reset state
    nxt(); nxt(); #1;
    check_reset_outputs("rst0");

    // zero-wait streaming
    reset = 1'b1; imem_ack = 1'b1; dec_ready = 1'b1; #1;
    check("zw.req0",  32'(imem_req),  32'd1);
    check("zw.addr0", imem_addr,      32'h0);
    check("zw.dv0",   32'(dec_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      nxt(); #1;
      check_head("zw", 32'(4 * i));
      check("zw.cnt", 32'(fq_count), 32'd1);
    end

    // backpressure fills the queue, then drains in order
    reset = 1'b0; dec_ready = 1'b0; nxt();
    reset = 1'b1; #1;
    repeat (10) nxt();
    #1;
    check("bp.cnt",  32'(fq_count), 32'd2);
    check("bp.req",  32'(imem_req), 32'd0);
    check("bp.addr", imem_addr,     32'h8);
    check_head("bp.h0", 32'h0);
    dec_ready = 1'b1; #1;
    check("bp.req_still0", 32'(imem_req), 32'd0);
    nxt(); #1;
    check_head("bp.h1", 32'h4);
    check("bp.cnt1",  32'(fq_count), 32'd1);
    check("bp.req1",  32'(imem_req), 32'd1);
    check("bp.addr1", imem_addr,     32'h8);
    nxt(); #1;
    check_head("bp.h2", 32'h8);

    // redirect while a slow request is outstanding -> DROP
    reset = 1'b0; imem_ack = 1'b0; nxt();
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_1002; #1;
    check("dr.req0",  32'(imem_req),  32'd1);
    check("dr.addr0", imem_addr,      32'h0);
    check("dr.dv0",   32'(dec_valid), 32'd0);
    for (int i = 1; i <= 2; i++) begin
      nxt(); redirect = 1'b0; #1;
      check("dr.req",  32'(imem_req),  32'd1);
      check("dr.addr", imem_addr,      32'h0);
      check("dr.dv",   32'(dec_valid), 32'd0);
      check("dr.cnt",  32'(fq_count),  32'd0);
    end
    nxt(); imem_ack = 1'b1; #1;
    check("dr.addr_ack", imem_addr, 32'h0);
    nxt(); imem_ack = 1'b0; #1;
    check("dr.req_new",  32'(imem_req),  32'd1);
    check("dr.addr_new", imem_addr,      32'h0000_1000);
    check("dr.dv_new",   32'(dec_valid), 32'd0);
    check("dr.cnt_new",  32'(fq_count),  32'd0);
    imem_ack = 1'b1;
    nxt(); #1;
    check_head("dr.first", 32'h0000_1000);

    // redirect coincident with ack and with a decode handshake
    redirect = 1'b1; redirect_pc = 32'h0000_2000; #1;
    check("rc.dv",   32'(dec_valid), 32'd0);
    check("rc.addr", imem_addr,      32'h0000_1004);
    nxt(); redirect = 1'b0; imem_ack = 1'b0; #1;
    check("rc.cnt",  32'(fq_count),  32'd0);
    check("rc.dv1",  32'(dec_valid), 32'd0);
    check("rc.req",  32'(imem_req),  32'd1);
    check("rc.addr1", imem_addr,     32'h0000_2000);
    imem_ack = 1'b1;
    nxt(); #1;
    check_head("rc.first", 32'h0000_2000);
    check("rc.cnt2", 32'(fq_count), 32'd1);

    // wraparound; low redirect bits are ignored
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
    check("wr.dv", 32'(dec_valid), 32'd0);
    nxt(); redirect = 1'b0; #1;
    check("wr.addr", imem_addr,     32'hFFFF_FFFC);
    check("wr.cnt",  32'(fq_count), 32'd0);
    nxt(); #1; check_head("wr.h0", 32'hFFFF_FFFC);
    nxt(); #1; check_head("wr.h1", 32'h0000_0000);
    nxt(); #1; check_head("wr.h2", 32'h0000_0004);

    // reset mid-stream with entries queued and a request outstanding
    dec_ready = 1'b0;
    nxt(); #1;
    check("mr.cnt_full", 32'(fq_count), 32'd2);
    check("mr.req_full", 32'(imem_req), 32'd0);
    imem_ack = 1'b0; dec_ready = 1'b1;
    nxt(); dec_ready = 1'b0; #1;
    check("mr.cnt1", 32'(fq_count), 32'd1);
    check("mr.req1", 32'(imem_req), 32'd1);
    check("mr.addr", imem_addr,     32'h0000_000C);
    check("mr.pc",   dec_pc,        32'h0000_0008);
    reset = 1'b0; #1;
    check("mr.req_withdrawn", 32'(imem_req), 32'd0);
    nxt(); #1;
    check_reset_outputs("mr.rst");
    reset = 1'b1; imem_ack = 1'b1; dec_ready = 1'b1; #1;
    check("mr.req_restart",  32'(imem_req), 32'd1);
    check("mr.addr_restart", imem_addr,     32'h0);
    nxt(); #1; check_head("mr.h0", 32'h0);
    nxt(); #1; check_head("mr.h1", 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end

endmodule
